// File: rtl/bpm_pkg.sv
// Shared widths and the result payload type for the bit-pair multiplier result path.
package bpm_pkg;
  localparam int PROD_W = 16;
  localparam int RES_W  = 17;

  typedef struct packed {
    logic              cout;
    logic [PROD_W-1:0] prod;
  } bpm_res_t;
endpackage

// File: rtl/bpm_res_fifo.sv
// First-word-fall-through result FIFO with explicit occupancy count.
// A push while full is accepted only if a pop frees the head on the same edge.
module bpm_res_fifo
  import bpm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = RES_W + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Data is forced to zero while empty so stale entries never leak out.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = data_i;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bpm_result_collect.sv
// Captures one multiplier result per rising edge of done_i, tags it, and queues it
// for a valid/ready consumer; flags completions lost to a full queue.
module bpm_result_collect
  import bpm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done_i,
  input  logic [PROD_W-1:0]      prod_i,
  input  logic                   cout_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [RES_W-1:0]       res_data_o,
  output logic [TAG_W-1:0]       res_tag_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   drop_o,
  input  logic                   drop_clr_i
);
  localparam int W = RES_W + TAG_W;

  logic             done_q, done_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             drop_q, drop_d;
  logic             cap, pop, empty;
  bpm_res_t         res_in, res_out;
  logic [W-1:0]     fifo_in, fifo_out;

  assign cap     = done_i & ~done_q;
  assign pop     = res_valid_o & res_ready_i;
  assign res_in  = '{cout: cout_i, prod: prod_i};
  assign fifo_in = {tag_q, res_in};

  bpm_res_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cap),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .full_o  (full_o),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign res_valid_o = ~empty;
  assign res_out     = bpm_res_t'(fifo_out[RES_W-1:0]);
  assign res_data_o  = res_out;
  assign res_tag_o   = fifo_out[W-1:RES_W];
  assign drop_o      = drop_q;

  always_comb begin
    done_d = done_i;
    // Tag advances even on a dropped capture so the consumer can see the gap.
    tag_d  = tag_q + TAG_W'(cap);
    drop_d = (cap & full_o & ~pop) | (drop_q & ~drop_clr_i);
  end

  // done_q resets high so a done level already present at release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b1;
      tag_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      done_q <= done_d;
      tag_q  <= tag_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: doc/bpm_result_collect.md
Name: bpm_result_collect

Overview:
- Downstream stage of the 8x8 bit-pair multiplier core and its sequencing FSM.
- Detects each completed multiply from the rising edge of the FSM `done` level, then captures the 16-bit product and carry-out into a small FIFO.
- Presents captured results on a valid/ready interface to the output-register/pad stage, with per-result sequence tags.
- Decouples the fixed-latency multiplier from a consumer that may stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the result sequence tag; wraps modulo 2^TAG_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- done_i  in  1  multiplier FSM done level; high from completion until the next FSM reset.
- prod_i  in  16  multiplier product; valid whenever done_i=1.
- cout_i  in  1  multiplier carry-out; valid whenever done_i=1.
- res_valid_o  out  1  head entry valid.
- res_ready_i  in  1  consumer accepts head when res_valid_o=1.
- res_data_o  out  17  {cout, prod[15:0]} of the head entry.
- res_tag_o  out  TAG_W  sequence tag of the head entry.
- count_o  out  $clog2(DEPTH)+1  entries held.
- full_o  out  1  count_o==DEPTH.
- drop_o  out  1  sticky: a completion was lost because the FIFO was full.
- drop_clr_i  in  1  synchronous clear of drop_o.

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - done_q=1, so a done_i already high at release is not a new event.
  - FIFO empty; tag counter=0; drop_o=0.
  - res_valid_o=0, res_data_o=0, res_tag_o=0, count_o=0, full_o=0.
- Event detection:
  - done_q registers done_i each cycle.
  - cap = done_i & ~done_q. Exactly one capture per low-to-high transition.
  - A done_i held high for many cycles produces one capture only.
- Capture:
  - On an edge with cap=1, the entry {cout_i, prod_i, tag} is pushed, sampled in the same cycle cap is high.
  - tag increments on every cap, including dropped captures, so the consumer sees gaps on loss.
- Handshake:
  - First-word-fall-through. res_data_o and res_tag_o reflect the head whenever res_valid_o=1; they are 0 when the FIFO is empty.
  - Pop occurs on an edge with res_valid_o & res_ready_i.
  - res_valid_o must not drop, and head data must not change, until that pop.
- Latency: cap at edge k into an empty FIFO gives res_valid_o=1 in the cycle after edge k. There is no bypass path.
- Full condition:
  - cap while full with no pop that edge: entry discarded, drop_o set, count unchanged.
  - cap while full with a pop that same edge: push accepted, count stays DEPTH.
- Empty condition: res_ready_i with res_valid_o=0 has no effect.
- Simultaneous push and pop when not empty: count unchanged; the head advances to the next entry.
- drop flag:
  - drop_clr_i and a new drop on the same edge: drop_o=1 (set wins).
  - drop_clr_i alone: drop_o=0 at the next edge.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. count_o is tracked explicitly.
- Width rules: the tag counter wraps from 2^TAG_W-1 to 0.

Decomposition:
- Package bpm_pkg:
  - PROD_W=16, RES_W=17.
  - typedef bpm_res_t: packed struct {logic cout; logic [15:0] prod;}.
- Sub-module bpm_res_fifo:
  - Parameterised on DEPTH and a payload width of RES_W+TAG_W.
  - Provides push, pop, full, empty and count.
- Top level holds edge detection, tag counter and the drop flag.

Test Plan:
- Reset release with done_i=1 -> no capture. Then done_i 0→1 with prod_i=16'h3840 (0x78*0x78), cout_i=0 -> next cycle res_valid_o=1, res_data_o=17'h03840, res_tag_o=0.
- done_i held high 20 cycles -> exactly one entry; count_o=1.
- res_ready_i=0, 5 done pulses with DEPTH=4 -> count_o=4, full_o=1, drop_o=1. Draining yields tags 0,1,2,3; the next capture carries tag 5.
- Full FIFO, cap and pop on the same edge -> count_o stays 4, no drop. Head advances; the new entry lands at the tail.
- 17 captures drained continuously with TAG_W=4 -> tags 0..15 then 0; product 0xFF*0xFF=16'hFE01 passes intact.
- Async reset asserted mid-stream with 3 entries held -> res_valid_o=0, count_o=0 immediately. After release the first capture carries tag 0.
